// File: rtl/chiplet_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : chiplet_tx_packetizer
// Function : Serialises decoded chiplet packets into FLIT_WIDTH-bit flits
//            (WPF 32-bit words per flit) with valid/ready backpressure.
// Revision : 1.0
// ============================================================================
module chiplet_tx_packetizer #(
    parameter int FLIT_WIDTH    = 40,
    parameter int MAX_DATA_BITS = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MAX_DATA_BITS+51:0] i_packetstream,
    input  logic                      i_packetstream_valid,
    output logic                      o_fsm_ready,
    output logic [FLIT_WIDTH-1:0]     o_flit,
    output logic                      o_flit_valid,
    input  logic                      i_flit_ready,
    output logic                      o_busy,
    output logic                      o_err,
    output logic [CNT_WIDTH-1:0]      o_pkt_count
);
    localparam int c_WPF   = FLIT_WIDTH / 32;
    localparam int c_LANES = c_WPF * 32;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_ADDR = 2'd2;
    localparam logic [1:0] c_DATA = 2'd3;

    localparam logic [2:0] c_CMD_RDREQ = 3'b000;
    localparam logic [2:0] c_CMD_RDRSP = 3'b010;

    logic                     w_mode;
    logic                     w_valid;
    logic [2:0]               w_cmd;
    logic [2:0]               w_len;
    logic [31:0]              w_addr;
    logic [MAX_DATA_BITS-1:0] w_data;
    logic [5:0]               w_f0;
    logic [5:0]               w_f1;
    logic [7:0]               w_hdr;
    logic [6:0]               w_nwords;
    logic [6:0]               w_nflits;
    logic [MAX_DATA_BITS-1:0] w_mask;
    logic                     w_illegal;
    logic                     w_hs;
    logic                     w_go_addr;
    logic                     w_go_data;
    logic                     w_done;
    logic [FLIT_WIDTH-1:0]    w_hdr_flit;
    logic [FLIT_WIDTH-1:0]    w_addr_flit;
    logic [FLIT_WIDTH-1:0]    w_data_flit;

    logic [1:0]               r_state_q,     r_state_d;
    logic                     r_ready_q,     r_ready_d;
    logic [FLIT_WIDTH-1:0]    r_flit_q,      r_flit_d;
    logic                     r_fv_q,        r_fv_d;
    logic                     r_busy_q,      r_busy_d;
    logic                     r_err_q,       r_err_d;
    logic [CNT_WIDTH-1:0]     r_cnt_q,       r_cnt_d;
    logic [31:0]              r_addr_q,      r_addr_d;
    logic [MAX_DATA_BITS-1:0] r_data_q,      r_data_d;
    logic [6:0]               r_dcnt_q,      r_dcnt_d;
    logic                     r_addr_flit_q, r_addr_flit_d;
    logic                     r_has_data_q,  r_has_data_d;

    assign w_mode   = i_packetstream[0];
    assign w_valid  = i_packetstream[1];
    assign w_cmd    = i_packetstream[4:2];
    assign w_len    = i_packetstream[7:5];
    assign w_addr   = i_packetstream[39:8];
    assign w_data   = i_packetstream[MAX_DATA_BITS+39:40];
    assign w_f0     = i_packetstream[MAX_DATA_BITS+45:MAX_DATA_BITS+40];
    assign w_f1     = i_packetstream[MAX_DATA_BITS+51:MAX_DATA_BITS+46];
    assign w_hdr    = {w_len, w_cmd, w_valid, w_mode};
    assign w_nwords = 7'd1 << w_len;
    assign w_nflits = 7'((32'(w_nwords) + c_WPF - 1) / c_WPF);
    // Words beyond the packet length are cleared so shifted-in lanes read as zero.
    assign w_mask   = ~({MAX_DATA_BITS{1'b1}} << {w_nwords, 5'd0});
    assign w_illegal = (w_cmd > 3'b010) || (w_len > 3'b101) ||
                       (32'({w_nwords, 5'd0}) > 32'(MAX_DATA_BITS));
    assign w_hs     = r_fv_q & i_flit_ready;

    always_comb begin
        w_hdr_flit = '0;
        if (w_mode) begin
            w_hdr_flit[19:0] = {w_f1, w_f0, w_hdr};
        end else begin
            w_hdr_flit[39:0] = {(w_cmd == c_CMD_RDRSP) ? 32'h0 : w_addr, w_hdr};
        end
        w_addr_flit        = '0;
        w_addr_flit[31:0]  = r_addr_q;
        w_data_flit        = '0;
        w_data_flit[c_LANES-1:0] = r_data_q[c_LANES-1:0];
    end

    always_comb begin
        r_state_d     = r_state_q;
        r_ready_d     = r_ready_q;
        r_flit_d      = r_flit_q;
        r_fv_d        = r_fv_q;
        r_busy_d      = r_busy_q;
        r_err_d       = 1'b0;
        r_cnt_d       = r_cnt_q;
        r_addr_d      = r_addr_q;
        r_data_d      = r_data_q;
        r_dcnt_d      = r_dcnt_q;
        r_addr_flit_d = r_addr_flit_q;
        r_has_data_d  = r_has_data_q;
        w_go_addr     = 1'b0;
        w_go_data     = 1'b0;
        w_done        = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                r_ready_d = 1'b1;
                if (i_packetstream_valid && r_ready_q && w_valid) begin
                    if (w_illegal) begin
                        r_err_d = 1'b1;
                    end else begin
                        r_state_d     = c_HDR;
                        r_ready_d     = 1'b0;
                        r_flit_d      = w_hdr_flit;
                        r_fv_d        = 1'b1;
                        r_busy_d      = 1'b1;
                        r_addr_d      = w_addr;
                        r_data_d      = w_data & w_mask;
                        r_dcnt_d      = w_nflits;
                        r_addr_flit_d = w_mode && (w_cmd != c_CMD_RDRSP);
                        r_has_data_d  = (w_cmd != c_CMD_RDREQ);
                    end
                end
            end
            c_HDR: begin
                if (w_hs) begin
                    w_go_addr = r_addr_flit_q;
                    w_go_data = !r_addr_flit_q && r_has_data_q;
                    w_done    = !r_addr_flit_q && !r_has_data_q;
                end
            end
            c_ADDR: begin
                if (w_hs) begin
                    w_go_data = r_has_data_q;
                    w_done    = !r_has_data_q;
                end
            end
            default: begin
                if (w_hs) begin
                    w_go_data = (r_dcnt_q != 7'd0);
                    w_done    = (r_dcnt_q == 7'd0);
                end
            end
        endcase

        if (w_go_addr) begin
            r_state_d = c_ADDR;
            r_flit_d  = w_addr_flit;
        end
        if (w_go_data) begin
            r_state_d = c_DATA;
            r_flit_d  = w_data_flit;
            r_data_d  = r_data_q >> c_LANES;
            r_dcnt_d  = r_dcnt_q - 7'd1;
        end
        if (w_done) begin
            r_state_d = c_IDLE;
            r_flit_d  = '0;
            r_fv_d    = 1'b0;
            r_busy_d  = 1'b0;
            r_ready_d = 1'b1;
            r_cnt_d   = r_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= c_IDLE;
            r_ready_q     <= 1'b0;
            r_flit_q      <= '0;
            r_fv_q        <= 1'b0;
            r_busy_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_cnt_q       <= '0;
            r_addr_q      <= '0;
            r_data_q      <= '0;
            r_dcnt_q      <= '0;
            r_addr_flit_q <= 1'b0;
            r_has_data_q  <= 1'b0;
        end else begin
            r_state_q     <= r_state_d;
            r_ready_q     <= r_ready_d;
            r_flit_q      <= r_flit_d;
            r_fv_q        <= r_fv_d;
            r_busy_q      <= r_busy_d;
            r_err_q       <= r_err_d;
            r_cnt_q       <= r_cnt_d;
            r_addr_q      <= r_addr_d;
            r_data_q      <= r_data_d;
            r_dcnt_q      <= r_dcnt_d;
            r_addr_flit_q <= r_addr_flit_d;
            r_has_data_q  <= r_has_data_d;
        end
    end

    assign o_fsm_ready  = r_ready_q;
    assign o_flit       = r_flit_q;
    assign o_flit_valid = r_fv_q;
    assign o_busy       = r_busy_q;
    assign o_err        = r_err_q;
    assign o_pkt_count  = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_chiplet_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chiplet_tx_packetizer
// Function : Scoreboard bench for chiplet_tx_packetizer at 40- and 72-bit flits.
// Revision : 1.0
// ============================================================================
module tb_chiplet_tx_packetizer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1075:0] pstream = '0;
    logic          pv40 = 1'b0, pv72 = 1'b0;
    logic          fr40 = 1'b1, fr72 = 1'b1;
    logic          rdy40, rdy72, fv40, fv72, busy40, busy72, err40, err72;
    logic [39:0]   flit40;
    logic [71:0]   flit72;
    logic [15:0]   cnt40, cnt72;

    int            errors = 0;
    int            checks = 0;
    int            nfl40  = 0;
    logic [71:0]   q40[$];
    logic [71:0]   q72[$];
    bit            stall40 = 0, stall72 = 0;
    logic [71:0]   hold40, hold72;

    always #5 clk = ~clk;

    chiplet_tx_packetizer #(.FLIT_WIDTH(40)) dut40 (
        .clk(clk), .rst(rst), .i_packetstream(pstream), .i_packetstream_valid(pv40),
        .o_fsm_ready(rdy40), .o_flit(flit40), .o_flit_valid(fv40), .i_flit_ready(fr40),
        .o_busy(busy40), .o_err(err40), .o_pkt_count(cnt40));

    chiplet_tx_packetizer #(.FLIT_WIDTH(72)) dut72 (
        .clk(clk), .rst(rst), .i_packetstream(pstream), .i_packetstream_valid(pv72),
        .o_fsm_ready(rdy72), .o_flit(flit72), .o_flit_valid(fv72), .i_flit_ready(fr72),
        .o_busy(busy72), .o_err(err72), .o_pkt_count(cnt72));

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1075:0] mk(input logic mode, input logic vb, input logic [2:0] cmd,
                                         input logic [2:0] len, input logic [31:0] addr,
                                         input logic [1023:0] data, input logic [5:0] f0,
                                         input logic [5:0] f1);
        return {f1, f0, data, addr, len, cmd, vb, mode};
    endfunction

    task automatic push(input bit sel, input logic [71:0] f);
        if (sel) q72.push_back(f);
        else     q40.push_back(f);
    endtask

    // Reference flit sequence built lane by lane from the packet fields.
    task automatic push_model(input bit sel, input int wpf, input logic mode, input logic [2:0] cmd,
                              input logic [2:0] len, input logic [31:0] addr,
                              input logic [1023:0] data, input logic [5:0] f0, input logic [5:0] f1);
        logic [71:0] f;
        logic [7:0]  hdr;
        int          n;
        hdr = {len, cmd, 1'b1, mode};
        f = '0;
        if (mode) f[19:0] = {f1, f0, hdr};
        else      f[39:0] = {(cmd == 3'b010) ? 32'h0 : addr, hdr};
        push(sel, f);
        if (mode && cmd != 3'b010) begin
            f = '0;
            f[31:0] = addr;
            push(sel, f);
        end
        if (cmd != 3'b000) begin
            n = 1 << len;
            for (int j = 0; j < (n + wpf - 1) / wpf; j++) begin
                f = '0;
                for (int m = 0; m < wpf; m++)
                    if (j * wpf + m < n) f[32*m +: 32] = data[32*(j*wpf+m) +: 32];
                push(sel, f);
            end
        end
    endtask

    task automatic send(input bit sel, input logic [1075:0] pkt);
        pstream = pkt;
        if (sel) pv72 = 1'b1;
        else     pv40 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ((sel ? rdy72 : rdy40) === 1'b1) break;
            tick();
        end
        check("accept_ready", {71'h0, sel ? rdy72 : rdy40}, 72'h1);
        tick();
        pv40 = 1'b0;
        pv72 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 200; i++) begin
            if (sel ? (!busy72 && q72.size() == 0) : (!busy40 && q40.size() == 0)) break;
            tick();
        end
        check("idle_queue", 72'(sel ? q72.size() : q40.size()), 72'h0);
        check("idle_busy", {71'h0, sel ? busy72 : busy40}, 72'h0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall40 = 0;
            stall72 = 0;
        end else begin
            if (stall40) check("hold40", {fv40, 31'h0, flit40}, {1'b1, hold40[70:0]});
            if (stall72) check("hold72", {fv72 ? flit72 : ~flit72}, hold72);
            stall40 = fv40 && !fr40;
            hold40  = {32'h0, flit40};
            stall72 = fv72 && !fr72;
            hold72  = flit72;
            if (fv40 && fr40) begin
                nfl40++;
                check("sb40_nonempty", 72'(q40.size() != 0), 72'h1);
                if (q40.size() != 0) check("flit40", {32'h0, flit40}, q40.pop_front());
            end
            if (fv72 && fr72) begin
                check("sb72_nonempty", 72'(q72.size() != 0), 72'h1);
                if (q72.size() != 0) check("flit72", flit72, q72.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] d;
        logic [1023:0] d2;
        int            nb;
        bit            found;

        tick(); tick();
        check("rst_ready40", {71'h0, rdy40}, 72'h0);
        check("rst_flit40", {32'h0, flit40}, 72'h0);
        check("rst_fv40", {71'h0, fv40}, 72'h0);
        check("rst_busy_err40", {70'h0, busy40, err40}, 72'h0);
        check("rst_cnt40", {56'h0, cnt40}, 72'h0);
        check("rst_all72", {rdy72 | fv72 | busy72 | err72, 39'h0, cnt72, 16'h0}, 72'h0);
        rst = 1'b0;
        tick();
        check("ready_after_rst40", {71'h0, rdy40}, 72'h1);
        check("ready_after_rst72", {71'h0, rdy72}, 72'h1);

        // Lightweight write, two words
        d = '0; d[31:0] = 32'hAA; d[63:32] = 32'hBB;
        push(0, 72'hFFDD000026); push(0, 72'hAA); push(0, 72'hBB);
        send(0, mk(1'b0, 1'b1, 3'b001, 3'b001, 32'hFFDD0000, d, 6'h0, 6'h0));
        check("hdr_latency", {71'h0, fv40}, 72'h1);
        check("ready_drop", {71'h0, rdy40}, 72'h0);
        check("busy_inflight", {71'h0, busy40}, 72'h1);
        wait_idle(0);
        check("ready_back", {71'h0, rdy40}, 72'h1);
        check("cnt_t1", {56'h0, cnt40}, 72'd1);

        // Extended write, four words
        d2 = '0; d2[31:0] = 32'h1234; d2[63:32] = 32'h5678; d2[95:64] = 32'h2444; d2[127:96] = 32'h3666;
        push(0, 72'hFC147); push(0, 72'h888); push(0, 72'h1234);
        push(0, 72'h5678); push(0, 72'h2444); push(0, 72'h3666);
        send(0, mk(1'b1, 1'b1, 3'b001, 3'b010, 32'h888, d2, 6'h01, 6'h3F));
        wait_idle(0);
        check("cnt_t2", {56'h0, cnt40}, 72'd2);

        // Lightweight read request
        push(0, 72'hAABB000022);
        send(0, mk(1'b0, 1'b1, 3'b000, 3'b001, 32'hAABB0000, d, 6'h0, 6'h0));
        wait_idle(0);
        check("cnt_t3", {56'h0, cnt40}, 72'd3);

        // Backpressure on the 5678 flit
        nb = nfl40;
        push(0, 72'hFC147); push(0, 72'h888); push(0, 72'h1234);
        push(0, 72'h5678); push(0, 72'h2444); push(0, 72'h3666);
        send(0, mk(1'b1, 1'b1, 3'b001, 3'b010, 32'h888, d2, 6'h01, 6'h3F));
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (fv40 && flit40 == 40'h5678) begin found = 1; break; end
            tick();
        end
        check("bp_reach", 72'(found), 72'h1);
        fr40 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {fv40, 31'h0, flit40}, {1'b1, 71'h5678});
        end
        fr40 = 1'b1;
        wait_idle(0);
        check("bp_flit_total", 72'(nfl40 - nb), 72'd6);
        check("cnt_t4", {56'h0, cnt40}, 72'd4);

        // Illegal and discarded packets
        send(0, mk(1'b0, 1'b1, 3'b111, 3'b001, 32'h1, d, 6'h0, 6'h0));
        check("err_cmd_pulse", {70'h0, err40, fv40}, 72'b10);
        tick();
        check("err_cmd_end", {70'h0, err40, fv40}, 72'b00);
        send(0, mk(1'b0, 1'b1, 3'b001, 3'b110, 32'h1, d, 6'h0, 6'h0));
        check("err_len_pulse", {70'h0, err40, fv40}, 72'b10);
        tick();
        check("err_len_end", {70'h0, err40, fv40}, 72'b00);
        send(0, mk(1'b0, 1'b0, 3'b001, 3'b001, 32'h1, d, 6'h0, 6'h0));
        check("novalid", {69'h0, err40, fv40, busy40}, 72'b000);
        tick();
        check("novalid_cnt", {55'h0, fv40, cnt40}, 72'd4);

        // Lightweight read response: address zeroed in header
        d = '0; d[31:0] = 32'hDEADBEEF;
        push_model(0, 1, 1'b0, 3'b010, 3'b000, 32'h12345678, d, 6'h0, 6'h0);
        send(0, mk(1'b0, 1'b1, 3'b010, 3'b000, 32'h12345678, d, 6'h0, 6'h0));
        wait_idle(0);

        // 72-bit: extended read response has no address flit
        d = '0; d[31:0] = 32'hCAFEF00D; d[63:32] = 32'h0BADBEEF;
        push_model(1, 2, 1'b1, 3'b010, 3'b001, 32'h55AA, d, 6'h15, 6'h2A);
        send(1, mk(1'b1, 1'b1, 3'b010, 3'b001, 32'h55AA, d, 6'h15, 6'h2A));
        wait_idle(1);

        // 72-bit: largest legal length with random data
        for (int k = 0; k < 32; k++) d[32*k +: 32] = $urandom;
        push_model(1, 2, 1'b0, 3'b001, 3'b101, 32'h0F0F0F0F, d, 6'h0, 6'h0);
        send(1, mk(1'b0, 1'b1, 3'b001, 3'b101, 32'h0F0F0F0F, d, 6'h0, 6'h0));
        wait_idle(1);
        check("cnt72_two", {56'h0, cnt72}, 72'd2);

        // 72-bit: scenario 2, reset during second data flit
        push(1, 72'hFC147); push(1, 72'h888);
        push(1, 72'h000000567800001234); push(1, 72'h000000366600002444);
        send(1, mk(1'b1, 1'b1, 3'b001, 3'b010, 32'h888, d2, 6'h01, 6'h3F));
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (fv72 && flit72 == 72'h000000366600002444) begin found = 1; break; end
            tick();
        end
        check("rst_mid_reach", 72'(found), 72'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_flit", flit72, 72'h0);
        check("rst_mid_ctl", {67'h0, rdy72, fv72, busy72, err72, 1'b0}, 72'h0);
        check("rst_mid_cnt", {56'h0, cnt72}, 72'h0);
        q72.delete();
        tick();
        rst = 1'b0;
        tick();
        check("ready_after_mid_rst", {70'h0, rdy72, fv72}, 72'b10);
        check("q40_drained", 72'(q40.size()), 72'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/chiplet_tx_packetizer.md
Name: chiplet_tx_packetizer

Overview:
Parametrised master-side TX packetizer for the chiplet link. It accepts one decoded packet per handshake (mode, valid, cmd, length, address, data, features) and serialises it into FLIT_WIDTH-bit flits with a valid/ready output handshake. It generalises the fixed 40-bit, one-word-per-flit TX FSM in three ways: it packs multiple 32-bit words per flit, applies backpressure on the flit side, and checks for illegal packets. It sits between the chiplet packet source and the link TX FIFO inside chiplet_sys.

Parameters:
FLIT_WIDTH, 40, flit width in bits; must be >= 40. WPF = FLIT_WIDTH/32, floor, gives data words per flit.
MAX_DATA_BITS, 1024, width of the data field in the input packet.
CNT_WIDTH, 16, width of the sent-packet counter.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_packetstream  in  MAX_DATA_BITS+52  packed fields, LSB first: mode[0], valid[1], cmd[4:2], length[7:5], addr[39:8], data[MAX_DATA_BITS+39:40], feature0 (6 bits), feature1 (6 bits, MSBs)
i_packetstream_valid  in  1  input packet present
o_fsm_ready  out  1  packetizer can accept a packet
o_flit  out  FLIT_WIDTH  output flit
o_flit_valid  out  1  flit valid
i_flit_ready  in  1  downstream accepts flit
o_busy  out  1  packet in flight
o_err  out  1  one-cycle pulse when an illegal packet is dropped
o_pkt_count  out  CNT_WIDTH  number of packets fully sent

Behaviour:
- Reset values: o_fsm_ready=0, o_flit=0, o_flit_valid=0, o_busy=0, o_err=0, o_pkt_count=0, state=IDLE.
- In the first cycle after reset deasserts, o_fsm_ready goes to 1.
- Packet acceptance:
  - A packet is accepted when i_packetstream_valid && o_fsm_ready at a rising edge.
  - o_fsm_ready is registered: 1 only in IDLE, and it drops in the cycle after an accept.
  - The whole packet is latched at accept.
- Packet checks at accept:
  - Packet with valid bit 0: discarded silently; stay in IDLE, no error.
  - cmd > 3'b010, length > 3'b101, or (1<<length)*32 > MAX_DATA_BITS: packet dropped, o_err pulses in the next cycle, no flits, stay in IDLE.
- Header byte is {length, cmd, valid, mode}.
- Lightweight packets (mode=0): header flit = {zero-pad, addr[31:0], hdr[7:0]}.
- Extended packets (mode=1): header flit = {zero-pad, feature1[19:14], feature0[13:8], hdr[7:0]}, followed by an address flit = {zero-pad, addr[31:0]}.
- Read response (cmd=010):
  - Address field is zeroed in a lightweight header.
  - No address flit is sent in extended mode.
- Data words:
  - Word count N = 1<<length. Data flit count = ceil(N/WPF).
  - Word k = data[32k+31:32k]. Flit j lane m (bits [32m+31:32m]) carries word j*WPF+m.
  - Unused lanes and bits are zero.
  - Read request (cmd=000) sends no data flits.
- FSM states: IDLE -> HDR -> (ADDR if extended and not a read response) -> (DATA if cmd != 000) -> IDLE.
  - Each state advances only on o_flit_valid && i_flit_ready.
  - DATA holds a flit counter and leaves after the last flit is accepted.
- Latency: the header flit is valid in the cycle after accept. With i_flit_ready held high, one flit goes out per cycle with no bubbles inside a packet.
- Back-to-back packets: o_fsm_ready returns in the cycle after the last flit handshake, so there is a 1-cycle gap between packets.
- Output handshake:
  - o_flit and o_flit_valid are registered.
  - While o_flit_valid=1 and i_flit_ready=0, o_flit must stay stable.
  - o_flit_valid never drops without a handshake.
- o_busy = 1 from the cycle after accept until the last flit is accepted.
- o_pkt_count increments on the last flit handshake of each packet and wraps modulo 2^CNT_WIDTH.
- Reset mid-packet: all outputs return to their reset values at once and the in-flight packet is lost.

Test Plan:
1. Lightweight write, length=001, addr=FFDD0000, data words AA,BB, FLIT_WIDTH=40, ready always high -> flits 40'hFFDD000026, 40'h00000000AA, 40'h00000000BB on consecutive cycles; o_pkt_count=1.
2. Extended write, length=010, addr=888, feature0=01, feature1=3F, data 1234,5678,2444,3666 -> flits 40'h00000FC147, 40'h0000000888, then 1234, 5678, 2444, 3666 in turn.
3. Lightweight read request, length=001, addr=AABB0000 -> single flit 40'hAABB000022; no data flits.
4. Backpressure: scenario 2 with i_flit_ready low for 3 cycles while the 5678 flit is valid -> o_flit holds 40'h0000005678 for those cycles; total 6 flits; no loss or duplication.
5. Illegal packets: cmd=111 -> o_err pulses for 1 cycle, no o_flit_valid; length=110 -> same. A packet with valid bit 0 -> no flits and no o_err.
6. FLIT_WIDTH=72, scenario 2 -> data flits 72'h000000567800001234, then 72'h000000366600002444. Then assert rst during the second data flit -> outputs are 0 at once, and o_fsm_ready=1 in the first cycle after reset deasserts.
